// File: rtl/alu_muldiv_seq_if.sv
// alu_muldiv_seq_if
//   Request/result bundle between the EX stage and the sequential
//   multiply/divide unit.
//   master : EX stage / hazard unit (drives start, op, src_a, src_b, flush)
//   slave  : alu_muldiv_seq (drives busy, done, hi, lo[, div_zero])
//   Build option MULDIV_DIVZERO_EN adds the div_zero result flag.
interface alu_muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef MULDIV_DIVZERO_EN
  logic             div_zero;
`endif

  modport master (
    output start, op, src_a, src_b, flush,
    input  busy, done, hi, lo
`ifdef MULDIV_DIVZERO_EN
    , input div_zero
`endif
  );

  modport slave (
    input  start, op, src_a, src_b, flush,
    output busy, done, hi, lo
`ifdef MULDIV_DIVZERO_EN
    , output div_zero
`endif
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq
//   Radix-2 iterative multiply/divide unit that owns the HI/LO pair.
//   One shift-add (mult) or restoring shift-subtract (div) step per cycle on
//   operand magnitudes, then one FIX cycle applies the sign correction and
//   writes HI/LO. MTHI/MTLO are single-cycle writes with no busy/done.
//   Ports:
//     clk, reset : rising-edge clock, asynchronous active-high reset
//     bus        : alu_muldiv_seq_if.slave
//                  in  start, op[2:0], src_a, src_b, flush
//                  out busy, done, hi, lo[, div_zero]
//   op: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//   Build option MULDIV_DIVZERO_EN: divide by zero finishes in one cycle and
//   raises div_zero with done; otherwise it runs full latency.
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             reset,
  alu_muldiv_seq_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mc_q, mc_d;      // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] p_q, p_d;        // {acc/rem, multiplier/dividend->quotient}
  logic               sa_q, sa_d, sb_q, sb_d;
  logic               div_q, div_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d;
`ifdef MULDIV_DIVZERO_EN
  logic               divz_q, divz_d;
`endif

  // operand magnitudes for the incoming request
  logic             op_signed;
  logic [WIDTH-1:0] a_abs, b_abs;
  assign op_signed = ~bus.op[0];
  assign a_abs = (op_signed && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
  assign b_abs = (op_signed && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;

  // multiply step: add multiplicand into upper half when LSB set, shift right
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} +
                   (p_q[0] ? {1'b0, mc_q} : {(WIDTH+1){1'b0}});

  // divide step: shift next dividend bit into remainder, trial subtract.
  // rem < divisor keeps rem_sh within WIDTH+1 bits, so diff[WIDTH] is the borrow.
  logic [WIDTH:0] rem_sh, div_diff;
  assign rem_sh   = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
  assign div_diff = rem_sh - {1'b0, mc_q};

  // sign fix-up of the magnitude result
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;
  assign mul_res = (sa_q ^ sb_q) ? -p_q : p_q;
  assign quo     = p_q[WIDTH-1:0];
  assign rem     = p_q[2*WIDTH-1:WIDTH];
  // with a zero divisor the remainder ends as |dividend|, so the dividend
  // sign restores src_a; the quotient is forced to all ones.
  assign fix_lo  = div_q ? (dz_q ? {WIDTH{1'b1}} : ((sa_q ^ sb_q) ? -quo : quo))
                         : mul_res[WIDTH-1:0];
  assign fix_hi  = div_q ? (sa_q ? -rem : rem) : mul_res[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mc_d    = mc_q;
    p_d     = p_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    div_d   = div_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MULDIV_DIVZERO_EN
    divz_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          if (!bus.op[2]) begin
            div_d   = bus.op[1];
            sa_d    = op_signed & bus.src_a[WIDTH-1];
            sb_d    = op_signed & bus.src_b[WIDTH-1];
            dz_d    = (bus.src_b == '0);
            mc_d    = bus.op[1] ? b_abs : a_abs;
            p_d     = bus.op[1] ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
            cnt_d   = CNT_W'(WIDTH);
            state_d = S_ITER;
`ifdef MULDIV_DIVZERO_EN
            if (bus.op[1] && bus.src_b == '0) begin
              state_d = S_DONE;
              hi_d    = bus.src_a;
              lo_d    = {WIDTH{1'b1}};
              divz_d  = 1'b1;
            end
`endif
          end else if (!bus.op[1]) begin
            if (bus.op[0]) lo_d = bus.src_a;
            else           hi_d = bus.src_a;
          end
        end
      end
      S_ITER: begin
        if (div_q) begin
          if (!div_diff[WIDTH]) p_d = {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
          else                  p_d = {rem_sh[WIDTH-1:0],   p_q[WIDTH-2:0], 1'b0};
        end else begin
          p_d = {mul_sum, p_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_DONE;
        hi_d    = fix_hi;
        lo_d    = fix_lo;
      end
      default: state_d = S_IDLE;
    endcase
    // squash wins over everything, including a same-cycle start or MTHI/MTLO
    if (bus.flush) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
`ifdef MULDIV_DIVZERO_EN
      divz_d  = 1'b0;
`endif
    end
    busy_d = (state_d == S_ITER) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mc_q    <= '0;
      p_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
      divz_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mc_q    <= mc_d;
      p_q     <= p_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      div_q   <= div_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MULDIV_DIVZERO_EN
      divz_q  <= divz_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
`ifdef MULDIV_DIVZERO_EN
  assign bus.div_zero = divz_q;
`endif
endmodule
